// File: rtl/mem_pkg.sv
// ============================================================================
// Module : mem_pkg
// Brief  : Shared access-size codes, controller state type and alignment check
//          for the data-RAM front end.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_RESP   = 2'd3
  } mac_state_t;

  // Only the two low address bits matter: no legal size spans more than 4 bytes.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_HALF: mis = addr_lo[0];
      SZ_WORD: mis = |addr_lo;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_ctrl_load_extend.sv
// ============================================================================
// Module : load_extend
// Brief  : Combinational sign/zero extension of right-justified RAM load data.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] result
);

  logic w_sb;
  logic w_sh;

  assign w_sb = is_signed & data[7];
  assign w_sh = is_signed & data[15];

  always_comb begin
    result = data;
    case (size)
      SZ_BYTE: result = {{24{w_sb}}, data[7:0]};
      SZ_HALF: result = {{16{w_sh}}, data[15:0]};
      default: result = data;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// ============================================================================
// Module : mem_access_ctrl
// Brief  : Single-outstanding load/store sequencer in front of ram256x8 with
//          alignment checking and an extended, registered load response.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic              ram_enable,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [1:0]        ram_size,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  mac_state_t        r_state;
  mac_state_t        w_next;
  logic              r_rw;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_enable;
  logic              r_resp_valid;
  logic [31:0]       r_resp_rdata;
  logic              r_resp_fault;
  logic              w_fault;
  logic              w_accept;
  logic [31:0]       w_ext;

  assign w_fault  = (req_size == SZ_BAD) | is_misaligned(req_size, req_addr[1:0]);
  assign w_accept = req_valid & (r_state == ST_IDLE);

  load_extend u_load_extend (
    .data      (ram_rdata),
    .size      (r_size),
    .is_signed (r_signed),
    .result    (w_ext)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (req_valid) w_next = w_fault ? ST_RESP : ST_SETUP;
      ST_SETUP:  w_next = ST_STROBE;
      ST_STROBE: w_next = ST_RESP;
      ST_RESP:   if (resp_ready) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_rw         <= 1'b0;
      r_size       <= SZ_BYTE;
      r_signed     <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_enable     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_fault <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_enable     <= (w_next == ST_STROBE);
      r_resp_valid <= (w_next == ST_RESP);
      if (w_accept) begin
        r_rw         <= req_rw;
        r_size       <= req_size;
        r_signed     <= req_signed;
        r_addr       <= req_addr;
        r_wdata      <= req_wdata;
        r_resp_fault <= w_fault;
        r_resp_rdata <= '0;
      end
      // RAM output is valid while Enable is high; capture it as STROBE ends.
      if (r_state == ST_STROBE) begin
        r_resp_rdata <= r_rw ? 32'd0 : w_ext;
      end
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_fault = r_resp_fault;
  assign ram_enable = r_enable;
  assign ram_rw     = r_rw;
  assign ram_addr   = r_addr;
  assign ram_size   = r_size;
  assign ram_wdata  = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// Module : tb_mem_access_ctrl
// Brief  : Randomized self-checking bench with a big-endian byte RAM and a
//          transaction-level reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_rw;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        ram_enable;
  logic        ram_rw;
  logic [7:0]  ram_addr;
  logic [1:0]  ram_size;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic [7:0]  ram  [256];
  logic [7:0]  refm [256];

  int          n_total;
  int          n_bad;
  logic [31:0] obs_rdata;

  mem_access_ctrl #(.ADDR_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rw     (req_rw),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .ram_enable (ram_enable),
    .ram_rw     (ram_rw),
    .ram_addr   (ram_addr),
    .ram_size   (ram_size),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-wide RAM stub, most significant byte at the lowest address.
  always @(posedge clk) begin
    if (ram_enable && ram_rw) begin
      case (ram_size)
        2'b00: ram[ram_addr] <= ram_wdata[7:0];
        2'b01: begin
          ram[ram_addr]        <= ram_wdata[15:8];
          ram[ram_addr + 8'd1] <= ram_wdata[7:0];
        end
        2'b10: begin
          ram[ram_addr]        <= ram_wdata[31:24];
          ram[ram_addr + 8'd1] <= ram_wdata[23:16];
          ram[ram_addr + 8'd2] <= ram_wdata[15:8];
          ram[ram_addr + 8'd3] <= ram_wdata[7:0];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ram_rdata = 32'd0;
    case (ram_size)
      2'b00: ram_rdata = {24'd0, ram[ram_addr]};
      2'b01: ram_rdata = {16'd0, ram[ram_addr], ram[ram_addr + 8'd1]};
      2'b10: ram_rdata = {ram[ram_addr], ram[ram_addr + 8'd1], ram[ram_addr + 8'd2], ram[ram_addr + 8'd3]};
      default: ram_rdata = 32'd0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_fault(input int size, input int addr);
    return (size == 3) || (size == 1 && addr % 2 != 0) || (size == 2 && addr % 4 != 0);
  endfunction

  function automatic logic [31:0] m_load(input int size, input bit sgn, input int addr);
    longint v;
    v = 0;
    if (size == 0) begin
      v = refm[addr];
      if (sgn && v >= 128) v = v - 256;
    end else if (size == 1) begin
      v = refm[addr] * 256 + refm[(addr + 1) % 256];
      if (sgn && v >= 32768) v = v - 65536;
    end else begin
      for (int i = 0; i < 4; i++) v = v * 256 + refm[(addr + i) % 256];
    end
    return v[31:0];
  endfunction

  function automatic void m_store(input int size, input int addr, input logic [31:0] wd);
    int n;
    longint w;
    n = (size == 0) ? 1 : (size == 1) ? 2 : 4;
    w = wd;
    for (int i = n - 1; i >= 0; i--) begin
      refm[(addr + i) % 256] = 8'(w % 256);
      w = w / 256;
    end
  endfunction

  task automatic run_req(input bit rw, input logic [1:0] size, input bit sgn,
                         input logic [7:0] addr, input logic [31:0] wd, input int hold);
    bit          flt;
    logic [31:0] exp;
    int          lat;
    int          en_cnt;
    flt = m_fault(int'(size), int'(addr));
    exp = (flt || rw) ? 32'd0 : m_load(int'(size), sgn, int'(addr));
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_rw = rw; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    en_cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 1 && !flt) begin
        chk("setup_en", 32'(ram_enable), 32'd0);
        chk("setup_addr", 32'(ram_addr), 32'(addr));
      end
      if (ram_enable) begin
        en_cnt++;
        chk("strobe_addr", 32'(ram_addr), 32'(addr));
        chk("strobe_size", 32'(ram_size), 32'(size));
        chk("strobe_rw", 32'(ram_rw), 32'(rw));
        chk("strobe_wdata", ram_wdata, wd);
      end
      if (resp_valid) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    chk("latency", 32'(lat), flt ? 32'd1 : 32'd3);
    chk("enable_cycles", 32'(en_cnt), flt ? 32'd0 : 32'd1);
    chk("rdata", resp_rdata, exp);
    chk("fault", 32'(resp_fault), 32'(flt));
    obs_rdata = resp_rdata;
    resp_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1; req_rw = 1'b1; req_size = 2'b00;
      req_addr = 8'($urandom); req_wdata = $urandom;
      @(negedge clk);
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_rdata", resp_rdata, exp);
      chk("hold_fault", 32'(resp_fault), 32'(flt));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      chk("hold_enable", 32'(ram_enable), 32'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    chk("idle_req_ready", 32'(req_ready), 32'd1);
    chk("idle_resp_valid", 32'(resp_valid), 32'd0);
    if (!flt && rw) m_store(int'(size), int'(addr), wd);
    for (int i = 0; i < 4; i++) begin
      chk("ram_bytes", 32'(ram[addr + 8'(i)]), 32'(refm[addr + 8'(i)]));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    chk({tag, "_resp_fault"}, 32'(resp_fault), 32'd0);
    chk({tag, "_ram_enable"}, 32'(ram_enable), 32'd0);
    chk({tag, "_ram_rw"}, 32'(ram_rw), 32'd0);
    chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    chk({tag, "_ram_size"}, 32'(ram_size), 32'd0);
    chk({tag, "_ram_wdata"}, ram_wdata, 32'd0);
  endtask

  initial begin
    logic [7:0]  a;
    logic [1:0]  sz;
    int          r;
    n_total = 0;
    n_bad = 0;
    obs_rdata = 32'd0;
    for (int i = 0; i < 256; i++) begin
      ram[i]  = 8'($urandom);
      refm[i] = ram[i];
    end
    rst_n = 1'b0; req_valid = 1'b0; req_rw = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 8'd0; req_wdata = 32'd0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    run_req(1'b1, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF, 0);
    chk("plan_b10", 32'(ram[8'h10]), 32'hDE);
    chk("plan_b11", 32'(ram[8'h11]), 32'hAD);
    chk("plan_b12", 32'(ram[8'h12]), 32'hBE);
    chk("plan_b13", 32'(ram[8'h13]), 32'hEF);
    run_req(1'b0, 2'b10, 1'b0, 8'h10, 32'd0, 0);
    chk("plan_lw", obs_rdata, 32'hDEADBEEF);
    run_req(1'b0, 2'b00, 1'b1, 8'h11, 32'd0, 0);
    chk("plan_lb_s", obs_rdata, 32'hFFFFFFAD);
    run_req(1'b0, 2'b00, 1'b0, 8'h11, 32'd0, 0);
    chk("plan_lb_u", obs_rdata, 32'h000000AD);
    run_req(1'b0, 2'b01, 1'b1, 8'h12, 32'd0, 0);
    chk("plan_lh_s", obs_rdata, 32'hFFFFBEEF);
    run_req(1'b1, 2'b01, 1'b0, 8'h21, 32'h12345678, 0);
    run_req(1'b1, 2'b10, 1'b0, 8'h22, 32'h12345678, 0);
    run_req(1'b1, 2'b11, 1'b0, 8'h20, 32'h12345678, 0);
    run_req(1'b1, 2'b10, 1'b0, 8'hFC, 32'hCAFEF00D, 0);
    run_req(1'b0, 2'b10, 1'b1, 8'hFC, 32'd0, 5);
    chk("plan_lw_fc", obs_rdata, 32'hCAFEF00D);

    // Reset while the store to 0x40 sits in SETUP.
    @(negedge clk);
    req_valid = 1'b1; req_rw = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 8'h40; req_wdata = ~{refm[8'h40], refm[8'h41], refm[8'h42], refm[8'h43]};
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("midrst_ram", 32'(ram[8'h40 + 8'(i)]), 32'(refm[8'h40 + 8'(i)]));
    end

    for (int t = 0; t < 120; t++) begin
      r  = int'($urandom_range(0, 6));
      sz = (r == 6) ? 2'b11 : 2'(r % 3);
      a  = 8'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      run_req(1'($urandom), sz, 1'($urandom), a, $urandom, int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
